// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Constants and types shared by the binary-network kernel stages.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    localparam int PSUM_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } kacc_state_t;

endpackage
`default_nettype wire

// File: rtl/kacc_adder.sv
`default_nettype none
// ============================================================================
// Module      : kacc_adder
// Description : Accumulator adder; clamps when KACC_SATURATE_EN, else wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module kacc_adder #(
    parameter int ACC_WIDTH  = 12,
    parameter int PSUM_WIDTH = 7
) (
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic [ACC_WIDTH-1:0]  sum_out
);

    logic [ACC_WIDTH:0] full_sum;

    assign full_sum = {1'b0, acc_in} + {{(ACC_WIDTH + 1 - PSUM_WIDTH){1'b0}}, psum_in};

`ifdef KACC_SATURATE_EN
    // Once clamped, further adds of non-negative psums keep the carry set.
    assign sum_out = full_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
`else
    logic unused_carry;
    assign unused_carry = full_sum[ACC_WIDTH];
    assign sum_out      = full_sum[ACC_WIDTH-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/kernel_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : kernel_accumulator
// Description : Sums NUM_CHANNELS partial sums per pixel and thresholds them
//               into a binary activation. Optional macro: KACC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_accumulator #(
    parameter int PSUM_WIDTH     = bnn_pkg::PSUM_WIDTH,
    parameter int ACC_WIDTH      = 12,
    parameter int NUM_CHANNELS   = 16,
    parameter int THRESH_DEFAULT = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  psum_valid_in,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic                  psum_ready_out,
    input  logic                  threshold_load_in,
    input  logic [ACC_WIDTH-1:0]  threshold_in,
    output logic                  act_valid_out,
    output logic                  act_out,
    output logic [ACC_WIDTH-1:0]  acc_out,
    input  logic                  out_ready_in
);

    import bnn_pkg::*;

    localparam int                CNT_W    = $clog2(NUM_CHANNELS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_CHANNELS - 1);

    kacc_state_t          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                 act_q, act_d;
    logic [ACC_WIDTH-1:0] threshold_q, threshold_d;

    logic [ACC_WIDTH-1:0] sum;
    logic                 accept;

    kacc_adder #(
        .ACC_WIDTH  (ACC_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
    ) u_adder (
        .acc_in  (acc_q),
        .psum_in (psum_in),
        .sum_out (sum)
    );

    assign psum_ready_out = (state_q != OUTPUT);
    assign act_valid_out  = (state_q == OUTPUT);
    assign act_out        = act_q;
    assign acc_out        = acc_out_q;
    assign accept         = psum_valid_in & psum_ready_out;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        act_d       = act_q;
        threshold_d = threshold_load_in ? threshold_in : threshold_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (count_q == LAST_CNT) begin
                        // Compare against the pre-load threshold; a same-cycle load is for the next pixel.
                        state_d   = OUTPUT;
                        acc_out_d = sum;
                        act_d     = (sum >= threshold_q);
                        count_d   = '0;
                        acc_d     = '0;
                    end else begin
                        state_d = ACCUM;
                        count_d = count_q + CNT_W'(1);
                        acc_d   = sum;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            act_q       <= 1'b0;
            threshold_q <= ACC_WIDTH'(THRESH_DEFAULT);
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            act_q       <= act_d;
            threshold_q <= threshold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_accumulator
// Description : Self-checking bench for kernel_accumulator (12-bit and 8-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_accumulator;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        psum_valid_in = 1'b0;
    logic [6:0]  psum_in = '0;
    logic        psum_ready_out;
    logic        threshold_load_in = 1'b0;
    logic [11:0] threshold_in = '0;
    logic        act_valid_out;
    logic        act_out;
    logic [11:0] acc_out;
    logic        out_ready_in = 1'b1;

    logic        v8 = 1'b0;
    logic [6:0]  p8 = '0;
    logic        r8;
    logic        av8;
    logic        a8;
    logic [7:0]  acc8;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int m_thresh = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    kernel_accumulator dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .psum_valid_in     (psum_valid_in),
        .psum_in           (psum_in),
        .psum_ready_out    (psum_ready_out),
        .threshold_load_in (threshold_load_in),
        .threshold_in      (threshold_in),
        .act_valid_out     (act_valid_out),
        .act_out           (act_out),
        .acc_out           (acc_out),
        .out_ready_in      (out_ready_in)
    );

    kernel_accumulator #(.ACC_WIDTH(8)) dut8 (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .psum_valid_in     (v8),
        .psum_in           (p8),
        .psum_ready_out    (r8),
        .threshold_load_in (1'b0),
        .threshold_in      (8'd0),
        .act_valid_out     (av8),
        .act_out           (a8),
        .acc_out           (acc8),
        .out_ready_in      (1'b1)
    );

    // Reference: a pixel is the arithmetic sum of its group, then wrapped or clamped.
    function automatic int model_sum(input int vals[$], input int w);
        int s = 0;
        foreach (vals[i]) s += vals[i];
`ifdef KACC_SATURATE_EN
        if (s > (1 << w) - 1) s = (1 << w) - 1;
`else
        s = s % (1 << w);
`endif
        return s;
    endfunction

    task automatic load_thresh(input int v);
        threshold_load_in = 1'b1;
        threshold_in      = 12'(v);
        @(posedge clk_in); #1;
        threshold_load_in = 1'b0;
        m_thresh          = v;
    endtask

    task automatic send_group(input int vals[$], input bit gapped, input bit ld_last, input int ld_val);
        int w;
        foreach (vals[i]) begin
            if (gapped && i > 0) begin
                psum_valid_in = 1'b0;
                @(posedge clk_in); #1;
            end
            psum_valid_in = 1'b1;
            psum_in       = 7'(vals[i]);
            if (ld_last && i == vals.size() - 1) begin
                threshold_load_in = 1'b1;
                threshold_in      = 12'(ld_val);
            end
            w = 0;
            while (!psum_ready_out && w < 20) begin
                @(posedge clk_in); #1;
                w++;
            end
            if (!psum_ready_out) begin
                checks++;
                $display("FAIL ready_timeout psum_ready_out=%0b required 1", psum_ready_out);
            end
            @(posedge clk_in); #1;
            threshold_load_in = 1'b0;
        end
        psum_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checks++; if (act_valid_out !== 1'b0) $display("FAIL rst_act_valid got %0b want 0", act_valid_out); else passes++;
        checks++; if (act_out !== 1'b0) $display("FAIL rst_act got %0b want 0", act_out); else passes++;
        checks++; if (acc_out !== 12'd0) $display("FAIL rst_acc got %0d want 0", acc_out); else passes++;
        checks++; if (psum_ready_out !== 1'b1) $display("FAIL rst_ready got %0b want 1", psum_ready_out); else passes++;
    endtask

    task automatic test_basic();
        int vals[$];
        logic [11:0] e_acc;
        logic        e_act;
        for (int k = 0; k < 6; k++) begin
            vals.delete();
            if (k < 2) begin
                load_thresh(k == 0 ? 64 : 81);
                repeat (16) vals.push_back(5);
            end else begin
                load_thresh($urandom_range(600, 1400));
                repeat (16) vals.push_back($urandom_range(0, 127));
            end
            e_acc = 12'(model_sum(vals, 12));
            e_act = (int'(e_acc) >= m_thresh);
            send_group(vals, 1'b0, 1'b0, 0);
            checks++; if (act_valid_out !== 1'b1) $display("FAIL basic_valid[%0d] got %0b want 1", k, act_valid_out); else passes++;
            checks++; if (acc_out !== e_acc) $display("FAIL basic_acc[%0d] got %0d want %0d", k, acc_out, e_acc); else passes++;
            checks++; if (act_out !== e_act) $display("FAIL basic_act[%0d] got %0b want %0b", k, act_out, e_act); else passes++;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_backpressure();
        int vals[$];
        logic [11:0] e_acc;
        logic        e_act;
        out_ready_in = 1'b0;
        repeat (16) vals.push_back($urandom_range(0, 127));
        e_acc = 12'(model_sum(vals, 12));
        e_act = (int'(e_acc) >= m_thresh);
        send_group(vals, 1'b0, 1'b0, 0);
        for (int c = 0; c < 3; c++) begin
            psum_valid_in = 1'b1;
            psum_in       = 7'($urandom_range(1, 127));
            @(posedge clk_in); #1;
            checks++; if (act_valid_out !== 1'b1) $display("FAIL bp_valid[%0d] got %0b want 1", c, act_valid_out); else passes++;
            checks++; if (psum_ready_out !== 1'b0) $display("FAIL bp_ready[%0d] got %0b want 0", c, psum_ready_out); else passes++;
            checks++; if (acc_out !== e_acc) $display("FAIL bp_acc[%0d] got %0d want %0d", c, acc_out, e_acc); else passes++;
            checks++; if (act_out !== e_act) $display("FAIL bp_act[%0d] got %0b want %0b", c, act_out, e_act); else passes++;
        end
        psum_valid_in = 1'b0;
        out_ready_in  = 1'b1;
        @(posedge clk_in); #1;
        checks++; if (act_valid_out !== 1'b0) $display("FAIL bp_release got %0b want 0", act_valid_out); else passes++;
        checks++; if (psum_ready_out !== 1'b1) $display("FAIL bp_ready_after got %0b want 1", psum_ready_out); else passes++;
        vals.delete();
        repeat (16) vals.push_back($urandom_range(0, 127));
        e_acc = 12'(model_sum(vals, 12));
        send_group(vals, 1'b0, 1'b0, 0);
        checks++; if (acc_out !== e_acc) $display("FAIL bp_next_acc got %0d want %0d", acc_out, e_acc); else passes++;
        @(posedge clk_in); #1;
    endtask

    task automatic test_overflow();
        int vals[$];
        logic [7:0] e_acc;
        int w;
        for (int k = 0; k < 2; k++) begin
            vals.delete();
            repeat (16) vals.push_back(k == 0 ? 20 : $urandom_range(40, 127));
            e_acc = 8'(model_sum(vals, 8));
            foreach (vals[i]) begin
                v8 = 1'b1;
                p8 = 7'(vals[i]);
                w  = 0;
                while (!r8 && w < 20) begin
                    @(posedge clk_in); #1;
                    w++;
                end
                @(posedge clk_in); #1;
            end
            v8 = 1'b0;
            checks++; if (av8 !== 1'b1) $display("FAIL ovf_valid[%0d] got %0b want 1", k, av8); else passes++;
            checks++; if (acc8 !== e_acc) $display("FAIL ovf_acc[%0d] got %0d want %0d", k, acc8, e_acc); else passes++;
            checks++; if (a8 !== 1'b1) $display("FAIL ovf_act[%0d] got %0b want 1", k, a8); else passes++;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset_mid();
        int vals[$];
        load_thresh(100);
        repeat (7) vals.push_back(9);
        send_group(vals, 1'b0, 1'b0, 0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in   = 1'b0;
        m_thresh = 0;
        checks++; if (psum_ready_out !== 1'b1) $display("FAIL rmid_ready got %0b want 1", psum_ready_out); else passes++;
        checks++; if (act_valid_out !== 1'b0) $display("FAIL rmid_valid got %0b want 0", act_valid_out); else passes++;
        vals.delete();
        repeat (16) vals.push_back(1);
        send_group(vals, 1'b0, 1'b0, 0);
        checks++; if (acc_out !== 12'(model_sum(vals, 12))) $display("FAIL rmid_acc got %0d want 16", acc_out); else passes++;
        checks++; if (act_out !== (16 >= m_thresh)) $display("FAIL rmid_act got %0b want 1", act_out); else passes++;
        @(posedge clk_in); #1;
    endtask

    task automatic test_threshold_race();
        int vals[$];
        logic e_act;
        load_thresh(50);
        for (int k = 0; k < 2; k++) begin
            vals.delete();
            repeat (15) vals.push_back(3);
            vals.push_back(5);
            e_act = (model_sum(vals, 12) >= m_thresh);
            send_group(vals, 1'b0, (k == 0), 100);
            if (k == 0) m_thresh = 100;
            checks++; if (acc_out !== 12'd50) $display("FAIL race_acc[%0d] got %0d want 50", k, acc_out); else passes++;
            checks++; if (act_out !== e_act) $display("FAIL race_act[%0d] got %0b want %0b", k, act_out, e_act); else passes++;
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_gapped();
        int vals[$];
        for (int i = 0; i < 16; i++) vals.push_back(i);
        send_group(vals, 1'b1, 1'b0, 0);
        checks++; if (act_valid_out !== 1'b1) $display("FAIL gap_valid got %0b want 1", act_valid_out); else passes++;
        checks++; if (acc_out !== 12'(model_sum(vals, 12))) $display("FAIL gap_acc got %0d want 120", acc_out); else passes++;
        @(posedge clk_in); #1;
    endtask

    task automatic test_back_to_back();
        int va[$];
        int vb[$];
        int ta;
        int tb;
        repeat (16) va.push_back($urandom_range(0, 127));
        repeat (16) vb.push_back($urandom_range(0, 127));
        send_group(va, 1'b0, 1'b0, 0);
        ta = cyc;
        checks++; if (acc_out !== 12'(model_sum(va, 12))) $display("FAIL b2b_acc_a got %0d want %0d", acc_out, model_sum(va, 12)); else passes++;
        send_group(vb, 1'b0, 1'b0, 0);
        tb = cyc;
        checks++; if (acc_out !== 12'(model_sum(vb, 12))) $display("FAIL b2b_acc_b got %0d want %0d", acc_out, model_sum(vb, 12)); else passes++;
        checks++; if (tb - ta !== 17) $display("FAIL b2b_period got %0d want 17", tb - ta); else passes++;
        @(posedge clk_in); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_threshold_race();
        test_gapped();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
